axi_hs_tracker: RTL

Parametrised multi-channel handshake tracker for the AXI interconnect. It generalises the single-channel write-address done flag to NUM_CH independent channels (AW, W, B, AR, R by default), each with:
- an outstanding-request counter,
- a stall watchdog,
- sticky protocol-error flags.

It sits beside the interconnect datapath as a passive monitor. Arbiters and decoders consume `done_o`/`full_o` to gate new requests.

---
 rtl/axi_hs_pkg.sv | 19 +
 rtl/axi_hs_chan_tracker.sv | 125 ++++++++++++
 rtl/axi_hs_tracker.sv | 48 ++++
 3 files changed

// File: rtl/axi_hs_pkg.sv
// Shared types and default parameters for the AXI handshake tracker.
package axi_hs_pkg;

  localparam int DEF_NUM_CH    = 5;
  localparam int DEF_MAX_OUTST = 4;
  localparam int DEF_TIMEOUT   = 256;

  typedef enum logic [1:0] {
    HS_IDLE  = 2'd0,
    HS_PEND  = 2'd1,
    HS_STALL = 2'd2
  } hs_state_e;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axi_hs_chan_tracker.sv
// One channel of the handshake tracker: outstanding counter, stall FSM with
// watchdog, and sticky protocol-error flags.
module axi_hs_chan_tracker
  import axi_hs_pkg::*;
#(
  parameter int MAX_OUTST = DEF_MAX_OUTST,
  parameter int CNT_W     = cnt_width(DEF_MAX_OUTST),
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int TO_W      = cnt_width(DEF_TIMEOUT)
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             valid_i,
  input  logic             ready_i,
  input  logic             req_i,
  input  logic             err_clr_i,
  output logic             done_o,
  output logic             full_o,
  output logic [CNT_W-1:0] outst_o,
  output logic             timeout_o,
  output logic             vdrop_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
  localparam bit               WD_EN   = (TIMEOUT != 0);

  hs_state_e        state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [TO_W-1:0]  wd_reg, wd_next, wd_inc;
  logic             valid_q, ready_q;
  logic             timeout_reg, vdrop_reg, ovf_reg;
  logic             hs, is_full, is_empty;
  logic             ovf_set, to_set, vdrop_set;

  assign hs        = valid_i & ready_i;
  assign is_full   = (count_reg == MAX_CNT);
  assign is_empty  = (count_reg == '0);
  assign vdrop_set = valid_q & ~ready_q & ~valid_i;
  assign wd_inc    = wd_reg + 1'b1;

  // A request paired with a handshake is a net no-op, even when full or empty.
  always_comb begin
    count_next = count_reg;
    ovf_set    = 1'b0;
    if (req_i && !hs) begin
      if (is_full) ovf_set = 1'b1;
      else         count_next = count_reg + 1'b1;
    end else if (hs && !req_i) begin
      if (is_empty) ovf_set = 1'b1;
      else          count_next = count_reg - 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    wd_next    = wd_reg;
    to_set     = 1'b0;
    case (state_reg)
      HS_IDLE: begin
        wd_next = '0;
        if (count_next != '0) state_next = HS_PEND;
      end
      HS_PEND: begin
        if (count_next == '0) begin
          state_next = HS_IDLE;
          wd_next    = '0;
        end else if (hs) begin
          wd_next = '0;
        end else if (WD_EN) begin
          wd_next = wd_inc;
          if (wd_inc == TO_MAX) begin
            state_next = HS_STALL;
            to_set     = 1'b1;
          end
        end
      end
      HS_STALL: begin
        // Watchdog holds saturated at TIMEOUT until traffic resumes.
        if (count_next == '0) begin
          state_next = HS_IDLE;
          wd_next    = '0;
        end else if (hs) begin
          state_next = HS_PEND;
          wd_next    = '0;
        end
      end
      default: begin
        state_next = HS_IDLE;
        wd_next    = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg   <= HS_IDLE;
      count_reg   <= '0;
      wd_reg      <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
      timeout_reg <= 1'b0;
      vdrop_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      wd_reg      <= wd_next;
      valid_q     <= valid_i;
      ready_q     <= ready_i;
      timeout_reg <= to_set    | (timeout_reg & ~err_clr_i);
      vdrop_reg   <= vdrop_set | (vdrop_reg   & ~err_clr_i);
      ovf_reg     <= ovf_set   | (ovf_reg     & ~err_clr_i);
    end
  end

  assign done_o    = is_empty;
  assign full_o    = is_full;
  assign outst_o   = count_reg;
  assign timeout_o = timeout_reg;
  assign vdrop_o   = vdrop_reg;
  assign ovf_o     = ovf_reg;

endmodule

// File: rtl/axi_hs_tracker.sv
// Passive multi-channel AXI handshake tracker: one independent channel
// tracker per AXI channel, outputs packed per channel index.
module axi_hs_tracker
  import axi_hs_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int MAX_OUTST = DEF_MAX_OUTST,
  parameter int CNT_W     = cnt_width(MAX_OUTST),
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int TO_W      = cnt_width(TIMEOUT)
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [NUM_CH-1:0]       valid_i,
  input  logic [NUM_CH-1:0]       ready_i,
  input  logic [NUM_CH-1:0]       req_i,
  input  logic                    err_clr_i,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       full_o,
  output logic [NUM_CH*CNT_W-1:0] outst_o,
  output logic [NUM_CH-1:0]       timeout_o,
  output logic [NUM_CH-1:0]       vdrop_o,
  output logic [NUM_CH-1:0]       ovf_o
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    axi_hs_chan_tracker #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT),
      .TO_W      (TO_W)
    ) u_chan (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .valid_i   (valid_i[gi]),
      .ready_i   (ready_i[gi]),
      .req_i     (req_i[gi]),
      .err_clr_i (err_clr_i),
      .done_o    (done_o[gi]),
      .full_o    (full_o[gi]),
      .outst_o   (outst_o[gi*CNT_W +: CNT_W]),
      .timeout_o (timeout_o[gi]),
      .vdrop_o   (vdrop_o[gi]),
      .ovf_o     (ovf_o[gi])
    );
  end

endmodule
